// File: rtl/alu_seq_if.sv
// Handshake bundle between operand fetch (master) and the sequential ALU (slave).
// Input side: in_valid/in_ready with command and operands. Output side: out_valid/out_ready with result and flags.
interface alu_seq_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       command;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             carryout;
    logic             zero;
    logic             overflow;

    modport master (
        output in_valid, command, operand_a, operand_b, out_ready,
        input  in_ready, out_valid, result, carryout, zero, overflow
    );

    modport slave (
        input  in_valid, command, operand_a, operand_b, out_ready,
        output in_ready, out_valid, result, carryout, zero, overflow
    );
endinterface

// File: rtl/alu_seq.sv
// Registered WIDTH-bit ALU: 8 logic/arith ops in one cycle, SLL/SRL/SRA iterated 1 bit/cycle.
// Optional ALU_STICKY_FLAGS_EN adds sticky carry/overflow bits with a flags_clr input.
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     rst_n,
    alu_seq_if.slave bus
`ifdef ALU_STICKY_FLAGS_EN
    ,
    input  logic     flags_clr,
    output logic     sticky_carry,
    output logic     sticky_overflow
`endif
);
    localparam int SHW = $clog2(WIDTH);
    localparam int MSB = WIDTH - 1;

    localparam logic [3:0] CMD_ADD  = 4'd0;
    localparam logic [3:0] CMD_SUB  = 4'd1;
    localparam logic [3:0] CMD_XOR  = 4'd2;
    localparam logic [3:0] CMD_SLT  = 4'd3;
    localparam logic [3:0] CMD_AND  = 4'd4;
    localparam logic [3:0] CMD_NAND = 4'd5;
    localparam logic [3:0] CMD_NOR  = 4'd6;
    localparam logic [3:0] CMD_OR   = 4'd7;
    localparam logic [3:0] CMD_SLL  = 4'd8;
    localparam logic [3:0] CMD_SRL  = 4'd9;
    localparam logic [3:0] CMD_SRA  = 4'd10;

    typedef enum logic {
        S_IDLE,
        S_SHIFT
    } state_t;

    typedef enum logic [1:0] {
        SH_SLL,
        SH_SRL,
        SH_SRA
    } shift_op_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_shift_data;
    logic [SHW-1:0]   r_shift_cnt;
    shift_op_t        r_shift_op;
    logic [WIDTH-1:0] r_result;
    logic             r_carry;
    logic             r_zero;
    logic             r_overflow;
    logic             r_out_valid;

    logic             w_in_ready;
    logic             w_accept;
    logic             w_out_xfer;
    logic             w_is_shift;
    logic [SHW-1:0]   w_shamt;
    shift_op_t        w_cmd_shift_op;
    logic [WIDTH-1:0] w_shift_step;
    logic [WIDTH:0]   w_add;
    logic [WIDTH:0]   w_sub;
    logic             w_add_ovf;
    logic             w_sub_ovf;
    logic             w_slt;
    logic [WIDTH-1:0] w_alu_result;
    logic             w_alu_carry;
    logic             w_alu_overflow;
    logic             w_shift_start;
    logic             w_load;
    logic [WIDTH-1:0] w_load_result;
    logic             w_load_carry;
    logic             w_load_overflow;

    // Single-entry: accept only when idle and the output slot is free or draining now.
    assign w_in_ready = (r_state == S_IDLE) && (!r_out_valid || bus.out_ready);
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_out_xfer = r_out_valid && bus.out_ready;
    assign w_shamt    = bus.operand_b[SHW-1:0];
    assign w_is_shift = (bus.command == CMD_SLL) || (bus.command == CMD_SRL) ||
                        (bus.command == CMD_SRA);

    // SLT takes A's sign when the signs differ, because A-B can overflow there.
    always_comb begin
        w_add     = {1'b0, bus.operand_a} + {1'b0, bus.operand_b};
        w_sub     = {1'b0, bus.operand_a} + {1'b0, ~bus.operand_b} + (WIDTH + 1)'(1);
        w_add_ovf = (bus.operand_a[MSB] == bus.operand_b[MSB]) && (w_add[MSB] != bus.operand_a[MSB]);
        w_sub_ovf = (bus.operand_a[MSB] != bus.operand_b[MSB]) && (w_sub[MSB] != bus.operand_a[MSB]);
        w_slt     = (bus.operand_a[MSB] != bus.operand_b[MSB]) ? bus.operand_a[MSB] : w_sub[MSB];
    end

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
        w_alu_result   = '0;
        w_alu_carry    = 1'b0;
        w_alu_overflow = 1'b0;
        case (bus.command)
            CMD_ADD: begin
                w_alu_result   = w_add[WIDTH-1:0];
                w_alu_carry    = w_add[WIDTH];
                w_alu_overflow = w_add_ovf;
            end
            CMD_SUB: begin
                w_alu_result   = w_sub[WIDTH-1:0];
                w_alu_carry    = w_sub[WIDTH];
                w_alu_overflow = w_sub_ovf;
            end
            CMD_XOR:  w_alu_result = bus.operand_a ^ bus.operand_b;
            CMD_SLT:  w_alu_result = {{(WIDTH - 1){1'b0}}, w_slt};
            CMD_AND:  w_alu_result = bus.operand_a & bus.operand_b;
            CMD_NAND: w_alu_result = ~(bus.operand_a & bus.operand_b);
            CMD_NOR:  w_alu_result = ~(bus.operand_a | bus.operand_b);
            CMD_OR:   w_alu_result = bus.operand_a | bus.operand_b;
            CMD_SLL, CMD_SRL, CMD_SRA: w_alu_result = bus.operand_a;
            default:  w_alu_result = '0;
        endcase
    end

    always_comb begin
        w_cmd_shift_op = SH_SRA;
        if (bus.command == CMD_SLL) begin
            w_cmd_shift_op = SH_SLL;
        end else if (bus.command == CMD_SRL) begin
            w_cmd_shift_op = SH_SRL;
        end
    end

    always_comb begin
        w_shift_step = r_shift_data;
        case (r_shift_op)
            SH_SLL:  w_shift_step = r_shift_data << 1;
            SH_SRL:  w_shift_step = r_shift_data >> 1;
            SH_SRA:  w_shift_step = {r_shift_data[MSB], r_shift_data[MSB:1]};
            default: w_shift_step = r_shift_data;
        endcase
    end

    always_comb begin
        w_state_next    = r_state;
        w_shift_start   = 1'b0;
        w_load          = 1'b0;
        w_load_result   = w_alu_result;
        w_load_carry    = w_alu_carry;
        w_load_overflow = w_alu_overflow;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_is_shift && (w_shamt != '0)) begin
                        w_state_next  = S_SHIFT;
                        w_shift_start = 1'b1;
                    end else begin
                        w_load = 1'b1;
                    end
                end
            end
            S_SHIFT: begin
                // Final step: the shifted value goes straight to the output registers.
                if (r_shift_cnt == SHW'(1)) begin
                    w_state_next    = S_IDLE;
                    w_load          = 1'b1;
                    w_load_result   = w_shift_step;
                    w_load_carry    = 1'b0;
                    w_load_overflow = 1'b0;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: the shift datapath is reset too, so an aborted shift leaves no stale operand behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift_data <= '0;
            r_shift_cnt  <= '0;
            r_shift_op   <= SH_SLL;
        end else if (w_shift_start) begin
            r_shift_data <= bus.operand_a;
            r_shift_cnt  <= w_shamt;
            r_shift_op   <= w_cmd_shift_op;
        end else if (r_state == S_SHIFT) begin
            r_shift_data <= w_shift_step;
            r_shift_cnt  <= r_shift_cnt - SHW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result    <= '0;
            r_carry     <= 1'b0;
            r_zero      <= 1'b0;
            r_overflow  <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (w_load) begin
            r_result    <= w_load_result;
            r_carry     <= w_load_carry;
            r_zero      <= (w_load_result == '0);
            r_overflow  <= w_load_overflow;
            r_out_valid <= 1'b1;
        end else if (w_out_xfer) begin
            r_out_valid <= 1'b0;
        end
    end

`ifdef ALU_STICKY_FLAGS_EN
    logic r_sticky_carry;
    logic r_sticky_overflow;

    // A set from a transferring flag takes priority over flags_clr on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sticky_carry    <= 1'b0;
            r_sticky_overflow <= 1'b0;
        end else begin
            if (w_out_xfer && r_carry) begin
                r_sticky_carry <= 1'b1;
            end else if (flags_clr) begin
                r_sticky_carry <= 1'b0;
            end
            if (w_out_xfer && r_overflow) begin
                r_sticky_overflow <= 1'b1;
            end else if (flags_clr) begin
                r_sticky_overflow <= 1'b0;
            end
        end
    end

    assign sticky_carry    = r_sticky_carry;
    assign sticky_overflow = r_sticky_overflow;
`endif

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.result    = r_result;
    assign bus.carryout  = r_carry;
    assign bus.zero      = r_zero;
    assign bus.overflow  = r_overflow;
endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq at WIDTH=32: expected results are queued on accept and compared on output transfer.
// Sticky-flag checks are compiled in when ALU_STICKY_FLAGS_EN is defined.
module tb_alu_seq;
    localparam int W = 32;

    typedef struct packed {
        logic [W-1:0] res;
        logic         c;
        logic         z;
        logic         v;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    int   cycle;
    bit   rand_rdy;
    exp_t sb_q[$];

    alu_seq_if #(.WIDTH(W)) bus ();

`ifdef ALU_STICKY_FLAGS_EN
    logic flags_clr;
    logic sticky_carry;
    logic sticky_overflow;
`endif

    alu_seq #(.WIDTH(W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus)
`ifdef ALU_STICKY_FLAGS_EN
        ,
        .flags_clr      (flags_clr),
        .sticky_carry   (sticky_carry),
        .sticky_overflow(sticky_overflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle++;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model written from the operation definitions using wide signed arithmetic.
    function automatic exp_t model(input logic [3:0] cmd, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t        e;
        longint      sa;
        longint      sb;
        longint      r;
        logic [W:0]  u;
        logic [4:0]  sh;
        e  = '0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sh = b[4:0];
        case (cmd)
            4'd0: begin
                u     = {1'b0, a} + {1'b0, b};
                e.res = u[W-1:0];
                e.c   = u[W];
                r     = sa + sb;
                e.v   = (r > 64'sh7FFF_FFFF) || (r < -64'sh8000_0000);
            end
            4'd1: begin
                e.res = a - b;
                e.c   = (a >= b);
                r     = sa - sb;
                e.v   = (r > 64'sh7FFF_FFFF) || (r < -64'sh8000_0000);
            end
            4'd2:  e.res = a ^ b;
            4'd3:  e.res = (sa < sb) ? 32'd1 : 32'd0;
            4'd4:  e.res = a & b;
            4'd5:  e.res = ~(a & b);
            4'd6:  e.res = ~(a | b);
            4'd7:  e.res = a | b;
            4'd8:  e.res = a << sh;
            4'd9:  e.res = a >> sh;
            4'd10: e.res = $signed(a) >>> sh;
            default: e.res = '0;
        endcase
        e.z = (e.res == '0);
        return e;
    endfunction

    // Output monitor: a transfer happens on the next rising edge when valid & ready at the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (sb_q.size() == 0) begin
                check("out_without_stim", 64'(bus.out_valid), 64'(0));
            end else begin
                e = sb_q.pop_front();
                check("result", 64'(bus.result), 64'(e.res));
                check("carryout", 64'(bus.carryout), 64'(e.c));
                check("zero", 64'(bus.zero), 64'(e.z));
                check("overflow", 64'(bus.overflow), 64'(e.v));
            end
        end
    end

    // Drives one command and returns at #1 after its accept edge, leaving in_valid asserted.
    task automatic send(input logic [3:0] cmd, input logic [W-1:0] a, input logic [W-1:0] b);
        bit ok;
        bit accepted;
        accepted      = 1'b0;
        bus.in_valid  = 1'b1;
        bus.command   = cmd;
        bus.operand_a = a;
        bus.operand_b = b;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            ok = bus.in_ready;
            @(posedge clk);
            #1;
            if (rand_rdy) bus.out_ready = ($urandom_range(0, 3) != 0);
            if (ok) begin
                sb_q.push_back(model(cmd, a, b));
                accepted = 1'b1;
                break;
            end
        end
        if (!accepted) check("accept_timeout", 64'(accepted), 64'(1));
    endtask

    // Counts accept-edge-relative cycles until out_valid; in_ready must stay low while busy.
    task automatic wait_out(output int lat);
        lat = 1;
        while (!bus.out_valid && lat < 100) begin
            check("in_ready_busy", 64'(bus.in_ready), 64'(0));
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic directed(input string tag, input logic [3:0] cmd, input logic [W-1:0] a,
                            input logic [W-1:0] b, input int exp_lat);
        int lat;
        send(cmd, a, b);
        bus.in_valid = 1'b0;
        wait_out(lat);
        check(tag, 64'(lat), 64'(exp_lat));
    endtask

    task automatic drain();
        for (int i = 0; i < 500; i++) begin
            if (sb_q.size() == 0 && !bus.out_valid) break;
            @(posedge clk);
            #1;
        end
        check("drain_empty", 64'(sb_q.size()), 64'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        logic [3:0] cmd;
        logic [W-1:0] a;
        logic [W-1:0] b;
        n_checks      = 0;
        n_fail        = 0;
        cycle         = 0;
        rand_rdy      = 1'b0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.command   = '0;
        bus.operand_a = '0;
        bus.operand_b = '0;
        bus.out_ready = 1'b1;
`ifdef ALU_STICKY_FLAGS_EN
        flags_clr     = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(bus.out_valid), 64'(0));
        check("rst_result", 64'(bus.result), 64'(0));
        check("rst_carry", 64'(bus.carryout), 64'(0));
        check("rst_zero", 64'(bus.zero), 64'(0));
        check("rst_overflow", 64'(bus.overflow), 64'(0));
        check("rst_in_ready", 64'(bus.in_ready), 64'(1));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        directed("lat_add_wrap", 4'd0, 32'hFFFF_FFFF, 32'h0000_0001, 1);
        directed("lat_sub_ovf", 4'd1, 32'h8000_0000, 32'h0000_0001, 1);
        directed("lat_slt_neg", 4'd3, 32'h8000_0000, 32'h0000_0001, 1);
        directed("lat_slt_pos", 4'd3, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1);
        directed("lat_sra4", 4'd10, 32'h8000_0000, 32'h0000_0004, 5);
        directed("lat_sll0", 4'd8, 32'h1234_5678, 32'hFFFF_FFE0, 1);
        directed("lat_srl3", 4'd9, 32'hF000_00F0, 32'h0000_0023, 4);
        directed("lat_cmd13", 4'd13, 32'hDEAD_BEEF, 32'h1234_5678, 1);
        drain();

        // Back-to-back non-shift ops must be accepted one per cycle.
        t0 = cycle;
        for (int i = 0; i < 8; i++) send(4'd0, $urandom, $urandom);
        check("b2b_cycles", 64'(cycle - t0), 64'(8));
        bus.in_valid = 1'b0;
        drain();

        // Output stall: result held and input blocked while out_ready is low.
        bus.out_ready = 1'b0;
        send(4'd0, 32'd5, 32'd6);
        bus.in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("stall_valid", 64'(bus.out_valid), 64'(1));
            check("stall_result", 64'(bus.result), 64'(11));
            check("stall_in_ready", 64'(bus.in_ready), 64'(0));
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        drain();

        // Reset in the middle of a long shift aborts it with no output.
        send(4'd8, 32'h0000_0001, 32'd20);
        bus.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("midshift_in_ready", 64'(bus.in_ready), 64'(0));
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", 64'(bus.out_valid), 64'(0));
        check("abort_in_ready", 64'(bus.in_ready), 64'(1));
        sb_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        directed("post_rst_add", 4'd0, 32'h0000_1000, 32'h0000_0234, 1);
        drain();

`ifdef ALU_STICKY_FLAGS_EN
        flags_clr = 1'b1;
        @(posedge clk);
        #1;
        flags_clr = 1'b0;
        check("sticky_clr_c", 64'(sticky_carry), 64'(0));
        check("sticky_clr_v", 64'(sticky_overflow), 64'(0));
        directed("lat_add_ovf", 4'd0, 32'h7FFF_FFFF, 32'h0000_0001, 1);
        @(posedge clk);
        #1;
        check("sticky_set_v", 64'(sticky_overflow), 64'(1));
        check("sticky_hold_c", 64'(sticky_carry), 64'(0));
        flags_clr = 1'b1;
        @(posedge clk);
        #1;
        flags_clr = 1'b0;
        check("sticky_cleared_v", 64'(sticky_overflow), 64'(0));
        drain();
`endif

        // Random mix of all commands with random output back-pressure.
        rand_rdy = 1'b1;
        for (int i = 0; i < 60; i++) begin
            cmd = 4'($urandom_range(0, 15));
            a   = ($urandom_range(0, 4) == 0) ? 32'h8000_0000 : $urandom;
            b   = ($urandom_range(0, 4) == 0) ? 32'h7FFF_FFFF : $urandom;
            send(cmd, a, b);
        end
        bus.in_valid  = 1'b0;
        rand_rdy      = 1'b0;
        bus.out_ready = 1'b1;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
